// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

  // Arbiter mode: ARB picks freely, BURST keeps the port with the current owner
  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of an index into NUM_REQ producers (at least one bit)
  function automatic int ptr_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Width of a burst counter able to hold the value MAX_BURST itself
  function automatic int cnt_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational rotate-priority encoder (module rr_pick)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      idx
);

  // Scan ptr, ptr+1, ... wrapping at NUM_REQ-1; the first requester found wins
  always_comb begin
    int pos;
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port; burst lock under FIFO_ARB_BURST_LOCK_EN
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din
);

  localparam int PW = ptr_w(NUM_REQ);

  if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
  end

  // Index after i, wrapping NUM_REQ-1 back to 0
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] pick_ptr;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic          sel_valid;
  logic [PW-1:0] sel_idx;
  logic          grant_ok;

  // Single priority encoder; in burst mode it also serves the handover search
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam int CW = cnt_w(MAX_BURST);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_burst;

  // Owner keeps the port while it still requests and has budget left;
  // otherwise the search starts just past the owner so handover costs no cycle
  always_comb begin
    hold_burst = (state_q == BURST) && req[owner_q] && (cnt_q < CW'(MAX_BURST));
    pick_ptr   = (state_q == BURST) ? next_idx(owner_q) : ptr_q;
    sel_valid  = hold_burst || pick_valid;
    sel_idx    = hold_burst ? owner_q : pick_idx;
  end

  // Next-state: a full FIFO freezes everything, including a burst in progress
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (!fifo_full) begin
      if (hold_burst) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pick_valid) begin
        state_d = BURST;
        owner_d = pick_idx;
        cnt_d   = CW'(1);
        ptr_d   = next_idx(pick_idx);
      end else if (state_q == BURST) begin
        state_d = ARB;
        ptr_d   = next_idx(owner_q);
      end
    end
  end

  // State registers; reset abandons any partial burst
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      state_q <= ARB;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  // Plain round robin: the pointer moves past whoever was just written
  always_comb begin
    pick_ptr  = ptr_q;
    sel_valid = pick_valid;
    sel_idx   = pick_idx;
    ptr_d     = ptr_q;
    if (!fifo_full && pick_valid) begin
      ptr_d = next_idx(pick_idx);
    end
  end

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Steer the selected word onto the FIFO port; nothing leaves while full or in reset
  always_comb begin
    grant_ok   = sel_valid && !fifo_full && !rst;
    gnt        = '0;
    fifo_din   = '0;
    fifo_wr_en = grant_ok;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_ok && (sel_idx == PW'(i))) begin
        gnt[i]   = 1'b1;
        fifo_din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized self-checking bench for fifo_wr_arbiter against a behavioural model
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: next priority index, current burst owner (-1 = none), words in burst
  int m_ptr   = 0;
  int m_owner = -1;
  int m_run   = 0;

  logic [N-1:0]  exp_gnt;
  logic          exp_wr;
  logic [DW-1:0] exp_din;
  int            exp_idx;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input logic [N-1:0] q, input int s);
    for (int k = 0; k < N; k++) begin
      if (q[(s + k) % N]) return (s + k) % N;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, predict the outputs, advance the model past the coming edge
  task automatic step(input logic r, input logic [N-1:0] q, input logic f);
`ifdef FIFO_ARB_BURST_LOCK_EN
    bit cont;
`endif
    @(negedge clk);
    rst       = r;
    req       = q;
    fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    exp_idx = -1;
`ifdef FIFO_ARB_BURST_LOCK_EN
    cont = (m_owner >= 0) && q[m_owner] && (m_run < MB);
    if (!r && !f) begin
      if (cont) exp_idx = m_owner;
      else exp_idx = first_from(q, (m_owner >= 0) ? (m_owner + 1) % N : m_ptr);
    end
`else
    if (!r && !f) exp_idx = first_from(q, m_ptr);
`endif
    exp_gnt = '0;
    exp_din = '0;
    exp_wr  = (exp_idx >= 0);
    if (exp_idx >= 0) begin
      exp_gnt[exp_idx] = 1'b1;
      exp_din = req_data[exp_idx*DW +: DW];
    end
    if (r) begin
      m_ptr = 0; m_owner = -1; m_run = 0;
    end else if (!f) begin
`ifdef FIFO_ARB_BURST_LOCK_EN
      if (cont) m_run++;
      else if (exp_idx >= 0) begin
        m_owner = exp_idx; m_run = 1; m_ptr = (exp_idx + 1) % N;
      end else if (m_owner >= 0) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end
`else
      if (exp_idx >= 0) m_ptr = (exp_idx + 1) % N;
`endif
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, '0, 1'b0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 4'b1111, 1'(c));
      n_checks++;
      if (gnt !== 4'b0000) $display("FAIL reset_gnt cyc %0d: got %b want 0000", c, gnt); else n_pass++;
      n_checks++;
      if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en cyc %0d: got %b want 0", c, fifo_wr_en); else n_pass++;
      n_checks++;
      if (fifo_din !== '0) $display("FAIL reset_din cyc %0d: got %h want 00", c, fifo_din); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] q_got[$];
    logic [DW-1:0] q_exp[$];
    int bad;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      step(1'b0, 4'b1111, 1'b0);
      n_checks++;
      if (gnt !== exp_gnt) $display("FAIL rr_gnt cyc %0d: got %b want %b", c, gnt, exp_gnt); else n_pass++;
`ifndef FIFO_ARB_BURST_LOCK_EN
      n_checks++;
      if (gnt !== (4'b0001 << (c % 4))) $display("FAIL rr_order cyc %0d: got %b want %b", c, gnt, 4'b0001 << (c % 4)); else n_pass++;
`endif
      if (fifo_wr_en) q_got.push_back(fifo_din);
      if (exp_wr) q_exp.push_back(exp_din);
    end
    n_checks++;
    if (q_got.size() !== 32) $display("FAIL rr_write_count: got %0d want 32", q_got.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < q_got.size() && i < q_exp.size(); i++) if (q_got[i] !== q_exp[i]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL rr_data_order: %0d words differ, want 0", bad); else n_pass++;
  endtask

  task automatic test_sparse();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b1010, 1'b0);
      n_checks++;
      if (gnt !== exp_gnt) $display("FAIL sparse_gnt cyc %0d: got %b want %b", c, gnt, exp_gnt); else n_pass++;
      n_checks++;
      if ((gnt & 4'b0101) !== 4'b0000) $display("FAIL sparse_idle_bits cyc %0d: got %b want x0x0", c, gnt); else n_pass++;
    end
  endtask

  task automatic test_full();
    int occ = 0;
    do_reset();
    for (int c = 0; c < 40 && occ < 32; c++) begin
      step(1'b0, 4'b1111, 1'b0);
      n_checks++;
      if (gnt !== exp_gnt) $display("FAIL fill_gnt cyc %0d: got %b want %b", c, gnt, exp_gnt); else n_pass++;
      if (exp_wr) occ++;
    end
    n_checks++;
    if (occ != 32) $display("FAIL fill_occupancy: got %0d want 32", occ); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 4'b1111, 1'b1);
      n_checks++;
      if (fifo_wr_en !== 1'b0) $display("FAIL full_wr_en cyc %0d: got %b want 0", c, fifo_wr_en); else n_pass++;
    end
    step(1'b0, 4'b1111, 1'b0);
    n_checks++;
    if (gnt !== 4'b0001) $display("FAIL full_resume_gnt: got %b want 0001", gnt); else n_pass++;
    n_checks++;
    if (fifo_din !== exp_din) $display("FAIL full_resume_din: got %h want %h", fifo_din, exp_din); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 4'b0010, 1'b0);
      n_checks++;
      if (gnt !== 4'b0010) $display("FAIL rstmid_pre cyc %0d: got %b want 0010", c, gnt); else n_pass++;
    end
    step(1'b1, 4'b0010, 1'b0);
    n_checks++;
    if (gnt !== 4'b0000) $display("FAIL rstmid_during: got %b want 0000", gnt); else n_pass++;
    step(1'b0, 4'b0110, 1'b0);
    n_checks++;
    if (gnt !== 4'b0010) $display("FAIL rstmid_after: got %b want 0010", gnt); else n_pass++;
  endtask

`ifdef FIFO_ARB_BURST_LOCK_EN
  task automatic test_burst_handover();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 4'b0011, 1'b0);
      n_checks++;
      if (gnt !== (4'b0001 << ((c / MB) % 2)))
        $display("FAIL burst_seq cyc %0d: got %b want %b", c, gnt, 4'b0001 << ((c / MB) % 2));
      else n_pass++;
    end
  endtask

  task automatic test_burst_drop();
    logic [N-1:0] want [8] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100};
    logic [N-1:0] reqs [8] = '{4'b1100, 4'b1100, 4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(1'b0, reqs[c], 1'b0);
      n_checks++;
      if (gnt !== want[c]) $display("FAIL burst_drop cyc %0d: got %b want %b", c, gnt, want[c]); else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    logic          r, f;
    logic [N-1:0]  q;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 39) == 0);
      f = ($urandom_range(0, 4) == 0);
      q = N'($urandom);
      step(r, q, f);
      n_checks++;
      if (gnt !== exp_gnt) $display("FAIL rand_gnt cyc %0d: got %b want %b", c, gnt, exp_gnt); else n_pass++;
      n_checks++;
      if (fifo_wr_en !== exp_wr) $display("FAIL rand_wr_en cyc %0d: got %b want %b", c, fifo_wr_en, exp_wr); else n_pass++;
      n_checks++;
      if (fifo_din !== exp_din) $display("FAIL rand_din cyc %0d: got %h want %h", c, fifo_din, exp_din); else n_pass++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    test_reset();
    test_round_robin();
    test_sparse();
    test_full();
    test_reset_mid_burst();
`ifdef FIFO_ARB_BURST_LOCK_EN
    test_burst_handover();
    test_burst_drop();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
